// File: rtl/intraloop_sched_if.sv
// Bundle of the scheduler's control, intrapred, transform-coder and reconstructor signals.
// slave is the scheduler's view; master is the environment's view.
interface intraloop_sched_if #(
  parameter int NUM_CH = 3,
  parameter int MBW    = 32,
  parameter int MODEW  = 3
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                    enable;
  logic                    start;
  logic [NUM_CH-1:0]       pred_valid;
  logic [NUM_CH*MODEW-1:0] pred_mode;
  logic [NUM_CH-1:0]       pred_ready;
  logic                    tc_valid;
  logic [CHW-1:0]          tc_ch;
  logic [MBW-1:0]          tc_mb;
  logic [MODEW-1:0]        tc_mode;
  logic                    tc_ready;
  logic                    recon_done;
  logic [CHW-1:0]          recon_ch;
  logic [NUM_CH-1:0]       fb;
  logic [NUM_CH*MBW-1:0]   mbnumber;
  logic                    busy;
  logic                    frame_done;
  logic                    err_ovf;

  modport slave (
    input  enable, start, pred_valid, pred_mode, tc_ready, recon_done, recon_ch,
    output pred_ready, tc_valid, tc_ch, tc_mb, tc_mode, fb, mbnumber, busy,
           frame_done, err_ovf
  );

  modport master (
    output enable, start, pred_valid, pred_mode, tc_ready, recon_done, recon_ch,
    input  pred_ready, tc_valid, tc_ch, tc_mb, tc_mode, fb, mbnumber, busy,
           frame_done, err_ovf
  );
endinterface

// File: rtl/intraloop_sched.sv
// Intra-loop frame scheduler: round-robin arbitration of predicted-block channels into
// the transform coder, credit-bounded in-flight count, per-channel mb numbering and retire feedback.
module intraloop_sched #(
  parameter int NUM_CH       = 3,
  parameter int MBW          = 32,
  parameter int MODEW        = 3,
  parameter int MB_PER_FRAME = 99,
  parameter int PIPE_DEPTH   = 4
) (
  input logic                clk,
  input logic                reset,
  intraloop_sched_if.slave   bus
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CRW = $clog2(PIPE_DEPTH + 1);
  localparam logic [CRW-1:0] CR_FULL = CRW'(PIPE_DEPTH);
  localparam logic [MBW-1:0] MB_MAX  = MBW'(MB_PER_FRAME);
  localparam logic [CHW-1:0] CH_LAST = CHW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [CHW-1:0]             rr_q, rr_d;
  logic [CRW-1:0]             credits_q, credits_d;
  logic [NUM_CH-1:0][MBW-1:0] count_q, count_d;
  logic                       tc_valid_q, tc_valid_d;
  logic [CHW-1:0]             tc_ch_q, tc_ch_d;
  logic [MBW-1:0]             tc_mb_q, tc_mb_d;
  logic [MODEW-1:0]           tc_mode_q, tc_mode_d;
  logic [NUM_CH-1:0]          fb_q, fb_d;
  logic                       err_q, err_d;

  logic [NUM_CH-1:0]          eligible;
  logic                       grant_found;
  logic [CHW-1:0]             grant_ch;
  logic [MODEW-1:0]           grant_mode;
  logic                       all_done;
  logic                       can_load;
  logic [NUM_CH-1:0]          pred_ready_c;
  logic                       recon_bad_ch;

  always_comb begin : grant_search
    int unsigned idx;
    idx         = 0;
    eligible    = '0;
    all_done    = 1'b1;
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      eligible[i] = bus.pred_valid[i] && (count_q[i] < MB_MAX);
      all_done    = all_done && (count_q[i] == MB_MAX);
    end
    // Search starts one past the last granted channel so every channel gets a turn.
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx = (32'(rr_q) + k) % NUM_CH;
      if (!grant_found && eligible[CHW'(idx)]) begin
        grant_found = 1'b1;
        grant_ch    = CHW'(idx);
      end
    end
  end

  always_comb begin
    grant_mode = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant_ch == CHW'(i)) grant_mode = bus.pred_mode[i*MODEW +: MODEW];
    end
  end

  // A held offer (valid without ready) blocks loads regardless of enable.
  assign can_load = (state_q == S_RUN) && bus.enable && (credits_q != '0) && grant_found &&
                    (!tc_valid_q || bus.tc_ready);

  always_comb begin
    pred_ready_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pred_ready_c[i] = can_load && (grant_ch == CHW'(i));
    end
  end

  assign recon_bad_ch = (int'(bus.recon_ch) >= NUM_CH);

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    credits_d  = credits_q;
    count_d    = count_q;
    tc_valid_d = tc_valid_q;
    tc_ch_d    = tc_ch_q;
    tc_mb_d    = tc_mb_q;
    tc_mode_d  = tc_mode_q;
    fb_d       = '0;
    err_d      = err_q;

    if (can_load) begin
      tc_valid_d        = 1'b1;
      tc_ch_d           = grant_ch;
      tc_mb_d           = count_q[grant_ch];
      tc_mode_d         = grant_mode;
      count_d[grant_ch] = count_q[grant_ch] + MBW'(1);
      rr_d              = grant_ch;
    end else if (bus.tc_ready) begin
      tc_valid_d = 1'b0;
    end

    case ({can_load, bus.recon_done})
      2'b10:   credits_d = credits_q - CRW'(1);
      2'b01:   credits_d = (credits_q == CR_FULL) ? CR_FULL : credits_q + CRW'(1);
      default: credits_d = credits_q;
    endcase

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      fb_d[i] = bus.recon_done && (bus.recon_ch == CHW'(i));
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start && bus.enable) begin
          state_d = S_RUN;
          count_d = '0;
          rr_d    = CH_LAST;
          err_d   = 1'b0;
        end
      end
      S_RUN:   if (all_done) state_d = S_DRAIN;
      S_DRAIN: if (credits_q == CR_FULL) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Set after the start-clear so an error in the start cycle is not lost.
    if (bus.recon_done && (recon_bad_ch || ((credits_q == CR_FULL) && !can_load))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rr_q       <= CH_LAST;
      credits_q  <= CR_FULL;
      count_q    <= '0;
      tc_valid_q <= 1'b0;
      tc_ch_q    <= '0;
      tc_mb_q    <= '0;
      tc_mode_q  <= '0;
      fb_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      credits_q  <= credits_d;
      count_q    <= count_d;
      tc_valid_q <= tc_valid_d;
      tc_ch_q    <= tc_ch_d;
      tc_mb_q    <= tc_mb_d;
      tc_mode_q  <= tc_mode_d;
      fb_q       <= fb_d;
      err_q      <= err_d;
    end
  end

  assign bus.pred_ready = pred_ready_c;
  assign bus.tc_valid   = tc_valid_q;
  assign bus.tc_ch      = tc_ch_q;
  assign bus.tc_mb      = tc_mb_q;
  assign bus.tc_mode    = tc_mode_q;
  assign bus.fb         = fb_q;
  assign bus.mbnumber   = count_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = (state_q == S_DONE);
  assign bus.err_ovf    = err_q;
endmodule

// File: tb/tb_intraloop_sched.sv
// Directed bench for intraloop_sched: expected offers queued at stimulus time,
// a negedge monitor pops and compares on every accepted offer.
module tb_intraloop_sched;
  localparam int NUM_CH = 3;
  localparam int MBW    = 8;
  localparam int MODEW  = 3;

  logic clk;
  logic rst_n;

  intraloop_sched_if #(.NUM_CH(NUM_CH), .MBW(MBW), .MODEW(MODEW)) bus ();

  intraloop_sched #(
    .NUM_CH(NUM_CH), .MBW(MBW), .MODEW(MODEW), .MB_PER_FRAME(3), .PIPE_DEPTH(4)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int fd_cnt = 0;
  int fb_cnt [NUM_CH] = '{0, 0, 0};

  logic [2:0]  modes [NUM_CH] = '{3'd1, 3'd5, 3'd6};
  logic [12:0] exp_q [$];

  logic       echo_en = 1'b0;
  logic       p0 = 1'b0, p1 = 1'b0;
  logic [1:0] p0_ch = '0, p1_ch = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input int mb);
    exp_q.push_back({2'(ch), 8'(mb), modes[ch]});
  endtask

  // One clock; also runs the reconstructor echo (retire two cycles after accept).
  task automatic tick();
    logic       acc;
    logic [1:0] ach;
    acc = bus.tc_valid && bus.tc_ready;
    ach = bus.tc_ch;
    @(posedge clk);
    #1;
    if (echo_en) begin
      bus.recon_done = p1;
      bus.recon_ch   = p1_ch;
    end
    p1    = p0;
    p1_ch = p0_ch;
    p0    = acc && echo_en;
    p0_ch = ach;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(input string name);
    int n;
    for (n = 0; n < 100; n++) begin
      tick();
      if (!bus.busy) break;
    end
    chk(name, 32'(n < 100), 32'd1);
  endtask

  initial begin : monitor
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (bus.frame_done) fd_cnt++;
      for (int i = 0; i < NUM_CH; i++) fb_cnt[i] += int'(bus.fb[i]);
      if (rst_n && bus.tc_valid && bus.tc_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: accepted ch %0d mb %0d mode %0d, none expected",
                   bus.tc_ch, bus.tc_mb, bus.tc_mode);
        end else begin
          e = exp_q.pop_front();
          chk("sb_ch_mb_mode", 32'({bus.tc_ch, bus.tc_mb, bus.tc_mode}), 32'(e));
        end
      end
    end
  end

  initial begin : stim
    int acc0, fd0, fb0;
    int fbs [NUM_CH];
    rst_n          = 1'b0;
    bus.enable     = 1'b0;
    bus.start      = 1'b0;
    bus.pred_valid = '0;
    bus.pred_mode  = {modes[2], modes[1], modes[0]};
    bus.tc_ready   = 1'b0;
    bus.recon_done = 1'b0;
    bus.recon_ch   = '0;
    cycles(2);

    chk("rst_tc_valid",   32'(bus.tc_valid), 32'd0);
    chk("rst_pred_ready", 32'(bus.pred_ready), 32'd0);
    chk("rst_mbnumber",   32'(bus.mbnumber), 32'd0);
    chk("rst_flags",      32'({bus.busy, bus.frame_done, bus.err_ovf, bus.fb}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Full frame, all channels, echoed retires.
    for (int mb = 0; mb < 3; mb++)
      for (int ch = 0; ch < NUM_CH; ch++) push(ch, mb);
    fd0 = fd_cnt;
    for (int i = 0; i < NUM_CH; i++) fbs[i] = fb_cnt[i];
    bus.enable = 1'b1; bus.pred_valid = 3'b111; bus.tc_ready = 1'b1; echo_en = 1'b1;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("frame_busy", 32'(bus.busy), 32'd1);
    wait_idle("frame_idle_timeout");
    chk("frame_done_once", 32'(fd_cnt - fd0), 32'd1);
    for (int i = 0; i < NUM_CH; i++) chk("frame_fb_count", 32'(fb_cnt[i] - fbs[i]), 32'd3);
    chk("frame_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("frame_mbnumber", 32'(bus.mbnumber), 32'h030303);
    chk("frame_err", 32'(bus.err_ovf), 32'd0);
    echo_en = 1'b0; bus.recon_done = 1'b0; bus.pred_valid = '0;
    tick();

    // Hold with tc_ready low, enable dropped mid-hold, then reset drops the offer.
    push(0, 0);
    bus.pred_valid = 3'b001; bus.tc_ready = 1'b0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("grant_pred_ready", 32'(bus.pred_ready), 32'b001);
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.enable = (i < 2);
      chk("hold_valid", 32'(bus.tc_valid), 32'd1);
      chk("hold_payload", 32'({bus.tc_ch, bus.tc_mb, bus.tc_mode}), 32'({2'd0, 8'd0, 3'd1}));
      chk("hold_pred_ready", 32'(bus.pred_ready), 32'd0);
      tick();
    end
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    chk("midrst_tc_valid", 32'(bus.tc_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_mbnumber", 32'(bus.mbnumber), 32'd0);
    chk("midrst_flags", 32'({bus.pred_ready, bus.frame_done, bus.err_ovf, bus.fb}), 32'd0);
    rst_n = 1'b1; bus.enable = 1'b1;
    tick();

    // Credit limit: four accepts without retires, then one per retire.
    push(0, 0); push(1, 0); push(2, 0); push(0, 1);
    acc0 = acc_cnt;
    bus.pred_valid = 3'b111; bus.tc_ready = 1'b1;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    cycles(10);
    chk("credit_stall_accepts", 32'(acc_cnt - acc0), 32'd4);
    chk("credit_stall_valid", 32'(bus.tc_valid), 32'd0);
    push(1, 1);
    acc0 = acc_cnt; fb0 = fb_cnt[0];
    bus.recon_done = 1'b1; bus.recon_ch = 2'd0; tick(); bus.recon_done = 1'b0;
    cycles(6);
    chk("credit_one_more", 32'(acc_cnt - acc0), 32'd1);
    chk("credit_fb0", 32'(fb_cnt[0] - fb0), 32'd1);

    // Retire coincident with a load leaves credits unchanged: two loads from two retires.
    push(2, 1); push(0, 2);
    acc0 = acc_cnt;
    bus.recon_done = 1'b1; bus.recon_ch = 2'd1; tick();
    bus.recon_ch = 2'd2; tick();
    bus.recon_done = 1'b0;
    cycles(5);
    chk("same_cycle_accepts", 32'(acc_cnt - acc0), 32'd2);
    chk("same_cycle_err", 32'(bus.err_ovf), 32'd0);

    // Out-of-range retire channel: error, no feedback, credit still returned.
    push(1, 2);
    acc0 = acc_cnt;
    bus.recon_done = 1'b1; bus.recon_ch = 2'd3; tick();
    bus.recon_done = 1'b0; bus.recon_ch = 2'd0;
    chk("badch_err", 32'(bus.err_ovf), 32'd1);
    chk("badch_no_fb", 32'(bus.fb), 32'd0);
    cycles(5);
    chk("badch_accepts", 32'(acc_cnt - acc0), 32'd1);
    chk("badch_mbnumber", 32'(bus.mbnumber), 32'h020303);

    // Retire while idle with full credits: sticky error until start.
    rst_n = 1'b0; bus.pred_valid = '0; tick(); rst_n = 1'b1; tick();
    chk("idle_err_clear", 32'(bus.err_ovf), 32'd0);
    bus.recon_done = 1'b1; tick(); bus.recon_done = 1'b0;
    chk("idle_ovf_set", 32'(bus.err_ovf), 32'd1);
    cycles(3);
    chk("idle_ovf_sticky", 32'(bus.err_ovf), 32'd1);

    // Only channel 2 active: it completes, FSM waits for the others.
    push(2, 0); push(2, 1); push(2, 2);
    acc0 = acc_cnt;
    bus.pred_valid = 3'b100; echo_en = 1'b1;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("start_clears_err", 32'(bus.err_ovf), 32'd0);
    cycles(15);
    chk("ch2_accepts", 32'(acc_cnt - acc0), 32'd3);
    chk("ch2_still_busy", 32'(bus.busy), 32'd1);
    chk("ch2_mbnumber", 32'(bus.mbnumber), 32'h030000);
    chk("ch2_valid_low", 32'(bus.tc_valid), 32'd0);
    push(0, 0); push(1, 0); push(0, 1); push(1, 1); push(0, 2); push(1, 2);
    fd0 = fd_cnt;
    bus.pred_valid = 3'b011;
    wait_idle("finish_idle_timeout");
    chk("finish_frame_done", 32'(fd_cnt - fd0), 32'd1);
    chk("finish_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("finish_err", 32'(bus.err_ovf), 32'd0);
    echo_en = 1'b0; bus.recon_done = 1'b0; bus.pred_valid = '0;
    cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
